// File: rtl/pad_mux_sequencer.sv
// Glitch-safe pad mux reconfiguration: only pads whose select changes are gated,
// switched after a guard interval, and released after a settle interval.
module pad_mux_sequencer #(
  parameter int NUM_PAD       = 14,
  parameter int MUX_W         = 4,
  parameter int GUARD_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [NUM_PAD*MUX_W-1:0] req_mux_i,
  output logic [NUM_PAD*MUX_W-1:0] pad_muxes_o,
  output logic [NUM_PAD-1:0]       pad_gate_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int BUS_W   = NUM_PAD * MUX_W;
  localparam int MAX_CYC = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISOLATE,
    SETTLE,
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [BUS_W-1:0]   pending_reg, pending_next;
  logic [NUM_PAD-1:0] mask_reg, mask_next;
  logic [BUS_W-1:0]   mux_reg, mux_next;
  logic [NUM_PAD-1:0] gate_reg, gate_next;
  logic               ready_reg, ready_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [NUM_PAD-1:0] change_mask;
  logic [BUS_W-1:0]   masked_mux;

  // Per-pad change detection and selective apply; unmasked pads keep their field.
  generate
    for (genvar gi = 0; gi < NUM_PAD; gi++) begin : g_pad
      assign change_mask[gi] = (req_mux_i[gi*MUX_W +: MUX_W] != mux_reg[gi*MUX_W +: MUX_W]);
      assign masked_mux[gi*MUX_W +: MUX_W] = mask_reg[gi] ? pending_reg[gi*MUX_W +: MUX_W]
                                                          : mux_reg[gi*MUX_W +: MUX_W];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      mux_reg     <= '0;
      gate_reg    <= '0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      mask_reg    <= mask_next;
      mux_reg     <= mux_next;
      gate_reg    <= gate_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    mask_next    = mask_reg;
    mux_next     = mux_reg;
    gate_next    = gate_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid_i && ready_reg) begin
          pending_next = req_mux_i;
          mask_next    = change_mask;
          if (|change_mask) begin
            state_next = ISOLATE;
            gate_next  = change_mask;
            cnt_next   = GUARD_LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      ISOLATE: begin
        if (cnt_reg == '0) begin
          mux_next   = masked_mux;
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          gate_next  = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        gate_next  = '0;
      end
      default: begin
        state_next = IDLE;
        gate_next  = '0;
      end
    endcase

    // Status flags are registered from the upcoming state so they align with it.
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
  end

  assign req_ready_o = ready_reg;
  assign pad_muxes_o = mux_reg;
  assign pad_gate_o  = gate_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule

// File: doc/pad_mux_sequencer.md
# pad_mux_sequencer

Glitch-safe sequencer for pad multiplexer reconfiguration, placed between the pad control register file and the pad ring mux cells. Software writes a complete mux configuration and hands it over with a valid/ready request. The sequencer isolates only the pads whose selection changes, switches their mux after a guard interval, and waits a settle interval before releasing them. No pad ever drives a transient peripheral signal during a mux change.

## Interface
- NUM_PAD, 14: number of muxed pads handled.
- MUX_W, 4: width of one pad mux select.
- GUARD_CYCLES, 4: cycles a pad is isolated before its mux changes; legal range ≥1.
- SETTLE_CYCLES, 8: cycles a pad stays isolated after its mux changes; legal range ≥1.
- clk_i  in  1  block clock; sole clock domain.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  new configuration offered.
- req_ready_o  out  1  sequencer can accept a configuration.
- req_mux_i  in  NUM_PAD×MUX_W  requested mux select per pad; sampled only on acceptance.
- pad_muxes_o  out  NUM_PAD×MUX_W  applied mux select per pad, to the pad ring.
- pad_gate_o  out  NUM_PAD  1 = pad output forced disabled (isolated).
- busy_o  out  1  sequence in progress (state ≠ IDLE).
- done_o  out  1  one-cycle pulse: configuration fully applied.

## Operation
- States: IDLE, ISOLATE, SETTLE, DONE.
- All outputs are registered. While rst_ni=0 at a clock edge:
  - pad_muxes_o=0, pad_gate_o=0, done_o=0, busy_o=0.
  - req_ready_o=1, state=IDLE, counter=0.
  - Pending configuration and change mask are cleared.
- IDLE:
  - req_ready_o=1.
  - Acceptance is req_valid_i && req_ready_o at a rising edge. On acceptance:
    - Capture req_mux_i into the pending register.
    - Compute the change mask, bitwise per pad: pending ≠ pad_muxes_o.
  - Mask nonzero: go to ISOLATE. pad_gate_o = mask. Counter loads GUARD_CYCLES-1.
  - Mask zero: go directly to DONE. No gating occurs.
- ISOLATE:
  - Counter decrements each cycle.
  - When the counter is 0: load pad_muxes_o from pending for masked pads only, go to SETTLE, counter loads SETTLE_CYCLES-1.
- SETTLE:
  - Counter decrements each cycle; pad_gate_o stays equal to the mask.
  - When the counter is 0: go to DONE and clear pad_gate_o.
- DONE:
  - Lasts one cycle. done_o=1, pad_gate_o=0, req_ready_o=0.
  - Next state is IDLE.
- Unmasked pads: their pad_gate_o bit is never asserted and their pad_muxes_o field never changes during a sequence.
- req_mux_i changes after acceptance have no effect. req_valid_i outside IDLE is ignored and is not queued; the requester holds valid until ready.
- busy_o=1 in ISOLATE, SETTLE and DONE.
- Counter width: $clog2(max(GUARD_CYCLES,SETTLE_CYCLES)+1). The counter never wraps.
- Reset mid-sequence: the next sampled rst_ni=0 edge forces all reset values immediately.
  - pad_muxes_o returns to 0, even if the sequence had partially applied.
  - Gates release in the same edge.

## Timing
- Accept edge = edge 0; cycle k is the cycle after edge k.
- Sequence with changes:
  - pad_gate_o high from cycle 1 through cycle GUARD+SETTLE.
  - pad_muxes_o takes new values in cycle GUARD+1.
  - DONE (done_o=1, gate low) in cycle GUARD+SETTLE+1.
  - req_ready_o=1 again in cycle GUARD+SETTLE+2.
- No-change request: done_o=1 in cycle 1, req_ready_o=1 in cycle 2.
- Minimum accept-to-accept spacing: GUARD+SETTLE+2 cycles with changes, 2 cycles without.
- Mux change always occurs strictly inside the gated window: at least GUARD gated cycles before it and SETTLE gated cycles including and after it.

## Test plan
- Reset: hold rst_ni=0 for 2 cycles with req_valid_i=1 -> pad_muxes_o=0, pad_gate_o=0, done_o=0, busy_o=0, req_ready_o=1; no acceptance occurs.
- Single change, G=4, S=8: request pad 3 → mux 2 -> pad_gate_o=0x0008 in cycles 1–12; pad_muxes_o[3]=2 from cycle 5; done_o only in cycle 13; ready in cycle 14.
- Multi-pad change: current pad 0=1, pad 1=0; request pad 0=1, pad 1=3, pad 2=1 -> mask 0x0006; pad 0 never gated and stays 1; pads 1 and 2 switch in cycle 5.
- No-change request: request equals current -> pad_gate_o stays 0, done_o in cycle 1, ready in cycle 2.
- Back-pressure: hold req_valid_i=1 during a sequence while changing req_mux_i -> second configuration is not captured until ready; first sequence applies the values sampled at edge 0; the second is accepted in cycle 14.
- Reset mid-SETTLE (cycle 7): assert rst_ni=0 -> next edge gives pad_muxes_o=0, pad_gate_o=0, done_o never pulses, ready=1 once rst_ni=1.
